// File: rtl/dmem_responder.sv
// Data-memory responder: byte-strobed 64-bit array behind valid/ready request and response channels.
// Optional macro DMEM_B2B_EN lets a new request be accepted on the same edge as the response handshake.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_wstrb,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_write
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_write;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_hs;
  logic          w_accept;
  logic          w_unused;

  assign w_idx    = req_addr[3 +: AW];
  assign w_err    = (req_addr[63:3] >= 61'(DEPTH));
  assign w_hs     = (r_state == S_RESP) && resp_ready;
  assign w_unused = ^req_addr[2:0];

`ifdef DMEM_B2B_EN
  assign req_ready = (r_state == S_IDLE) || w_hs;
`else
  assign req_ready = (r_state == S_IDLE);
`endif

  // Gate with rst so a request held during reset never reaches the (unreset) array.
  assign w_accept = req_valid && req_ready && rst;

  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign resp_write = r_write;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_RESP;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (w_hs) w_state_next = S_IDLE;
      end
      default: ;
    endcase
    // A new accept (from IDLE, or back-to-back from RESP) always restarts the latency.
    if (w_accept) begin
      if (LATENCY == 1) begin
        w_state_next = S_RESP;
        w_cnt_next   = 4'd0;
      end else begin
        w_state_next = S_WAIT;
        w_cnt_next   = 4'(LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_err   <= w_err;
        r_write <= req_write;
        r_rdata <= (!req_write && !w_err) ? r_mem[w_idx] : 64'd0;
      end else if (w_hs) begin
        r_rdata <= 64'd0;
        r_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wstrb[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 1, 3, 4), vector table,
// hand-written corner sequences and randomized traffic against a byte-level memory model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic        clk;
  logic        rst;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [63:0] req_addr   [NI];
  logic [7:0]  req_wstrb  [NI];
  logic [63:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [63:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        resp_write [NI];

  int checks = 0;
  int errors = 0;

  logic [63:0] mm [int];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(gi == 0 ? 1 : (gi == 1 ? 3 : 4))
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_write (req_write[gi]),
        .req_addr  (req_addr[gi]),
        .req_wstrb (req_wstrb[gi]),
        .req_wdata (req_wdata[gi]),
        .resp_valid(resp_valid[gi]),
        .resp_ready(resp_ready[gi]),
        .resp_rdata(resp_rdata[gi]),
        .resp_err  (resp_err[gi]),
        .resp_write(resp_write[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: memory as a map of words, each store merges the enabled bytes.
  function automatic void mdl(int k, bit wr, logic [63:0] addr, logic [7:0] strb,
                              logic [63:0] wd, output logic [63:0] erd, output logic eerr);
    longint unsigned w;
    int key;
    logic [63:0] t;
    w    = addr >> 3;
    eerr = (w >= DEPTH);
    erd  = 64'd0;
    if (eerr) return;
    key = k * DEPTH + int'(w);
    t = mm.exists(key) ? mm[key] : 64'hx;
    if (wr) begin
      for (int b = 0; b < 8; b++) if (strb[b]) t[8*b +: 8] = wd[8*b +: 8];
      mm[key] = t;
    end else begin
      erd = t;
    end
  endfunction

  task automatic txn(int k, int lat, bit wr, logic [63:0] addr, logic [7:0] strb,
                     logic [63:0] wd, int stall, output logic [63:0] rd,
                     output logic er, output logic wb,
                     output logic [63:0] erd, output logic eer);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
    req_wstrb[k] = strb; req_wdata[k] = wd;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_ready timeout", 0, 1);
    @(posedge clk);
    mdl(k, wr, addr, strb, wd, erd, eer);
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (!resp_valid[k] && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("latency inst%0d", k), 64'(n), 64'(lat));
    rd = resp_rdata[k]; er = resp_err[k]; wb = resp_write[k];
    for (int s = 0; s < stall; s++) begin
      chk("stall req_ready", req_ready[k], 0);
      @(negedge clk);
      chk("stall resp_valid", resp_valid[k], 1);
      chk("stall rdata stable", resp_rdata[k], rd);
    end
    resp_ready[k] = 1'b1;
`ifndef DMEM_B2B_EN
    #1 chk("req_ready during RESP", req_ready[k], 0);
`endif
    @(posedge clk);
    #1 resp_ready[k] = 1'b0;
    chk("post-hs resp_valid", resp_valid[k], 0);
    chk("post-hs rdata", resp_rdata[k], 0);
    chk("post-hs req_ready", req_ready[k], 1);
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [63:0] rd, erd, a;
    logic er, wb, eer;
    bit wr;
    int edges, got, issued, bad;
    bit acc, hs;
    logic [63:0] saddr[4];
    logic [63:0] sexp[4];

    tbl[0]  = '{1'b1, 64'h10,   8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 64'h10,   8'h00, 64'h0, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{1'b1, 64'h10,   8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 64'h10,   8'h00, 64'h0, 64'h11223344BBBBBBBB, 1'b0};
    tbl[4]  = '{1'b1, 64'h0,    8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b0};
    tbl[5]  = '{1'b1, 64'h2000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
    tbl[6]  = '{1'b0, 64'h0,    8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b0};
    tbl[7]  = '{1'b0, 64'h2000, 8'h00, 64'h0, 64'h0, 1'b1};
    tbl[8]  = '{1'b1, 64'h1FF8, 8'hFF, 64'hCAFEF00D12345678, 64'h0, 1'b0};
    tbl[9]  = '{1'b1, 64'h1FF8, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 64'h1FF8, 8'h00, 64'h0, 64'hCAFEF00D12345678, 1'b0};
    tbl[11] = '{1'b0, 64'h1FFF, 8'h00, 64'h0, 64'hCAFEF00D12345678, 1'b0};
    tbl[12] = '{1'b0, 64'hFFFF000000000000, 8'h00, 64'h0, 64'h0, 1'b1};

    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 0; req_write[k] = 0; req_addr[k] = 0;
      req_wstrb[k] = 0; req_wdata[k] = 0; resp_ready[k] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset with a store request held: it must not reach the array.
    txn(0, 1, 1'b1, 64'h8, 8'hFF, 64'h5555555555555555, 0, rd, er, wb, erd, eer);
    @(negedge clk);
    rst = 1'b0;
    req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 64'h8;
    req_wstrb[0] = 8'hFF; req_wdata[0] = 64'hDEADBEEFDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset req_ready", req_ready[0], 1);
      chk("reset resp_valid", resp_valid[0], 0);
      chk("reset rdata", resp_rdata[0], 0);
      chk("reset err", resp_err[0], 0);
      chk("reset write", resp_write[0], 0);
    end
    req_valid[0] = 0;
    rst = 1'b1;
    txn(0, 1, 1'b0, 64'h8, 8'h00, 64'h0, 0, rd, er, wb, erd, eer);
    chk("no write during reset", rd, 64'h5555555555555555);

    for (int i = 0; i < 13; i++) begin
      txn(0, 1, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wd, i % 3, rd, er, wb, erd, eer);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d err", i), er, tbl[i].exp_err);
      chk($sformatf("vec%0d write", i), wb, tbl[i].wr);
    end

    // LATENCY=3 with 5 cycles of response backpressure.
    txn(1, 3, 1'b1, 64'h18, 8'hFF, 64'h0F1E2D3C4B5A6978, 0, rd, er, wb, erd, eer);
    chk("lat3 store ack", wb, 1);
    txn(1, 3, 1'b0, 64'h18, 8'h00, 64'h0, 5, rd, er, wb, erd, eer);
    chk("lat3 load rdata", rd, 64'h0F1E2D3C4B5A6978);
    chk("lat3 load err", er, 0);

    // resp_ready asserted while idle is ignored.
    @(negedge clk);
    resp_ready[0] = 1;
    @(negedge clk);
    chk("idle resp_ready ignored", resp_valid[0], 0);
    resp_ready[0] = 0;

    // Reset while LATENCY=4 load is in WAIT: response dropped.
    @(negedge clk);
    req_valid[2] = 1; req_write[2] = 0; req_addr[2] = 64'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 0;
    chk("wait resp_valid", resp_valid[2], 0);
    chk("wait req_ready", req_ready[2], 0);
    rst = 1'b0;
    #1 chk("async reset req_ready", req_ready[2], 1);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid[2] !== 1'b0) bad++;
    end
    chk("dropped response never valid", 64'(bad), 0);

    // Streamed loads with resp_ready held high.
    saddr[0] = 64'h0; saddr[1] = 64'h8; saddr[2] = 64'h10; saddr[3] = 64'h1FF8;
    for (int i = 0; i < 4; i++) mdl(0, 1'b0, saddr[i], 8'h00, 64'h0, sexp[i], eer);
    @(negedge clk);
    resp_ready[0] = 1; req_valid[0] = 1; req_write[0] = 0; req_addr[0] = saddr[0];
    edges = 0; got = 0; issued = 0;
    while (got < 4 && edges < 40) begin
      acc = req_valid[0] && req_ready[0];
      hs  = resp_valid[0];
      if (hs) begin
        chk($sformatf("stream resp%0d", got), resp_rdata[0], sexp[got]);
`ifndef DMEM_B2B_EN
        chk("stream req_ready in RESP", req_ready[0], 0);
`endif
        got++;
      end
      @(posedge clk);
      edges++;
      if (acc) issued++;
      @(negedge clk);
      req_valid[0] = (issued < 4);
      if (issued < 4) req_addr[0] = saddr[issued];
    end
    resp_ready[0] = 0; req_valid[0] = 0;
    chk("stream responses", 64'(got), 4);
`ifdef DMEM_B2B_EN
    chk("stream cycles", 64'(edges), 5);
`else
    chk("stream cycles", 64'(edges), 8);
`endif

    // Randomized traffic against the model.
    for (int w = 3; w < 8; w++)
      txn(0, 1, 1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom}, 0, rd, er, wb, erd, eer);
    for (int i = 0; i < 40; i++) begin
      wr = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0)
        a = 64'h2000 + 64'($urandom_range(0, 1000)) * 8 + 64'($urandom_range(0, 7));
      else
        a = 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      txn(0, 1, wr, a, 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 2),
          rd, er, wb, erd, eer);
      chk($sformatf("rand%0d rdata", i), rd, erd);
      chk($sformatf("rand%0d err", i), er, eer);
      chk($sformatf("rand%0d write", i), wb, wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage: the target end of the load/store port.
- Accepts one request at a time over a valid/ready request channel and applies byte-strobed writes to a 64-bit-wide internal array.
- Returns read data or a write acknowledgement over a valid/ready response channel after a programmable latency, so the pipeline can be exercised against slow memory.

Parameters:
DEPTH, 1024, number of 64-bit words; power of two, >= 2
LATENCY, 1, cycles from the request-accept edge to resp_valid rising; range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset; outputs and state only, array contents not reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  64  byte address; bits [2:0] ignored
req_wstrb  input  8  byte write enables; bit i covers wdata[8i+7:8i]
req_wdata  input  64  store data, already lane-aligned
resp_valid  output  1  response present
resp_ready  input  1  MEM stage accepts the response
resp_rdata  output  64  load data, full 64-bit word; 0 for stores and errors
resp_err  output  1  address out of range
resp_write  output  1  echo of req_write for the held response

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_write=0, FSM=IDLE, latency counter=0.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- Word index = req_addr[3 +: log2(DEPTH)].
- Out of range: req_addr[63:3] >= DEPTH sets err.
- Accept-edge actions:
  - store, in range: each byte with req_wstrb[i]=1 is written on the accept edge; the write is committed immediately and is not undone by a later reset.
  - load, in range: the array word is captured into the response register on the accept edge (read-before-write ordering is irrelevant, since there is one request per edge).
  - err: no array write; resp_rdata=0, resp_err=1.
  - wstrb=0 store: legal no-op write; still acknowledged.
- FSM:
  - IDLE: req_ready=1. On accept: if LATENCY==1 go to RESP, else go to WAIT with cnt=LATENCY-1.
  - WAIT: req_ready=0, resp_valid=0. cnt decrements each cycle; when cnt==1 go to RESP next edge.
  - RESP: resp_valid=1 with stable rdata/err/write until resp_ready. On the handshake edge go to IDLE and clear resp_valid/rdata/err.
- Latency: for a response accepted immediately, resp_valid is first high LATENCY cycles after the accept edge; minimum request-to-request spacing = LATENCY+1 cycles.
- Backpressure: resp_ready low holds RESP indefinitely; all response outputs stay stable; req_ready stays 0.
- resp_ready asserted outside RESP: ignored.
- Async reset mid-operation (WAIT or RESP): the pending response is dropped, FSM returns to IDLE, outputs take reset values; a store accepted before reset remains in the array.
- Simultaneous events (base build): a request presented in the same cycle as the RESP handshake is not accepted (req_ready=0); it is accepted the following cycle.
- No combinational path from req_* to resp_*; req_ready depends on state only (base build).

Optional Feature:
- Macro: DMEM_B2B_EN.
- Defined: in RESP, req_ready = resp_ready. A request handshaking on the same edge as the response handshake is accepted; the FSM goes directly to RESP (LATENCY==1) or WAIT, with the new response data loaded. Sustained throughput is one request per LATENCY cycles. This introduces a combinational resp_ready->req_ready path.
- Undefined: behaviour exactly as the base build above; no resp_ready->req_ready path.

Test Plan:
- Reset, LATENCY=1: rst low 3 cycles with req_valid=1 -> req_ready=1, resp_valid=0, and no array write occurs.
- Store addr 0x10, wstrb 0xFF, wdata 0x1122334455667788; then load 0x10 -> store ack resp_write=1, rdata=0, err=0; load returns 0x1122334455667788 one cycle after its accept.
- Partial store addr 0x10, wstrb 0x0F, wdata 0xAAAAAAAABBBBBBBB; then load -> 0x11223344BBBBBBBB.
- LATENCY=3, load addr 0x18 with resp_ready held 0 for 5 cycles -> resp_valid rises 3 cycles after accept; rdata stable throughout; req_ready=0 until the handshake edge.
- Out-of-range store addr 8*DEPTH (0x2000), wdata all-ones, then load 0x0 -> err=1, rdata=0; word 0 unchanged.
- rst asserted while in WAIT (LATENCY=4, load pending) -> resp_valid never rises; req_ready=1 immediately.
- With DMEM_B2B_EN, LATENCY=1: 4 back-to-back loads with resp_ready=1 -> one response per cycle, in order.
